fpm_result_packer: RTL

Output end of the floating-point multiplier pipeline. The operand buffer stage delivers unpacked fields: 24-bit mantissas with the hidden bit, biased 8-bit exponents, and signs. This block does the reverse: it takes the 48-bit mantissa product plus the operand exponents and signs, then normalizes, rounds (nearest-even), handles special cases and packs an IEEE-754 single-precision result. It is a 2-stage valid/ready pipeline so the multiplier can be back-pressured by the consumer.

---
 rtl/fpm_result_packer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fpm_result_packer.sv
// fpm_result_packer: back end of the single-precision multiplier.
// Takes the 48-bit mantissa product plus the operand exponents and signs.
// Stage 1 normalizes and rounds (nearest-even). Stage 2 resolves the special
// cases and packs the IEEE-754 word. Both stages are valid/ready and can be stalled.
module fpm_result_packer #(
  parameter int BIAS    = 127,
  parameter int EXP_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] p_m,
  input  logic [7:0]  a_e,
  input  logic [7:0]  b_e,
  input  logic        a_s,
  input  logic        b_s,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf
);

  localparam logic [7:0]        EXP_SPECIAL = 8'(EXP_MAX);
  localparam logic signed [9:0] BIAS_S      = 10'(BIAS);
  localparam logic signed [9:0] E_OVF       = 10'(EXP_MAX);

  // Nearest-even increment; bit 23 of the return is the carry out of the fraction
  function automatic logic [23:0] round_rne(input logic [22:0] frac,
                                            input logic        guard,
                                            input logic        sticky);
    logic inc;
    inc = guard & (sticky | frac[0]);
    return {1'b0, frac} + {23'b0, inc};
  endfunction

  // Special-case priority and packing; returns {result, ovf, unf}
  function automatic logic [33:0] pack_result(input logic               s,
                                              input logic               inf,
                                              input logic               nan,
                                              input logic               zero,
                                              input logic signed [9:0]  e,
                                              input logic [22:0]        frac);
    if (nan)             return {32'h7FC0_0000, 2'b00};
    else if (inf)        return {s, 8'hFF, 23'h0, 2'b00};
    else if (zero)       return {s, 31'h0, 2'b00};
    else if (e >= E_OVF) return {s, 8'hFF, 23'h0, 2'b10};
    else if (e <= 10'sd0) return {s, 31'h0, 2'b01};
    else                 return {s, e[7:0], frac, 2'b00};
  endfunction

  logic                vld_p1;
  logic                s_p1;
  logic                inf_p1;
  logic                nan_p1;
  logic                zero_p1;
  logic signed [9:0]   e_p1;
  logic [22:0]         frac_p1;
  logic                s1_adv;

  logic                n_p0;
  logic [22:0]         frac_raw_p0;
  logic                guard_p0;
  logic                sticky_p0;
  logic [23:0]         rnd_p0;
  logic signed [9:0]   e_p0;
  logic                inf_p0;
  logic                zero_p0;
  logic [33:0]         pack_p1;

  assign s1_adv   = ~out_valid | out_ready;
  assign in_ready = ~vld_p1 | s1_adv;

  // ---- stage 0 -> 1: normalize, round, decode operand specials ----
  assign n_p0        = p_m[47];
  assign frac_raw_p0 = n_p0 ? p_m[46:24] : p_m[45:23];
  assign guard_p0    = n_p0 ? p_m[23]    : p_m[22];
  assign sticky_p0   = n_p0 ? |p_m[22:0] : |p_m[21:0];
  assign rnd_p0      = round_rne(frac_raw_p0, guard_p0, sticky_p0);
  // A rounding carry out of an all-ones fraction leaves frac=0 and bumps the exponent
  assign e_p0 = $signed({2'b00, a_e}) + $signed({2'b00, b_e}) - BIAS_S
              + $signed({9'b0, n_p0}) + $signed({9'b0, rnd_p0[23]});
  assign inf_p0  = (a_e == EXP_SPECIAL) | (b_e == EXP_SPECIAL);
  assign zero_p0 = (a_e == 8'd0) | (b_e == 8'd0);

  // Stage 1 occupancy: loads whenever the stage can move
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
  end

  // Stage 1 payload: captured only on an accepted transfer
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s_p1    <= a_s ^ b_s;
      inf_p1  <= inf_p0;
      nan_p1  <= inf_p0 & zero_p0;
      zero_p1 <= zero_p0;
      e_p1    <= e_p0;
      frac_p1 <= rnd_p0[22:0];
    end
  end

  // ---- stage 1 -> 2: special cases and packing ----
  assign pack_p1 = pack_result(s_p1, inf_p1, nan_p1, zero_p1, e_p1, frac_p1);

  // Output register: holds its value while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= 32'h0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        result <= pack_p1[33:2];
        ovf    <= pack_p1[1];
        unf    <= pack_p1[0];
      end
    end
  end

endmodule
